// File: rtl/sd_pkt_replay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkt_replay_pkg
// Description : State encoding and EOP index helper for sd_pkt_replay.
// Revision    : 1.0
// ============================================================================
package sd_pkt_replay_pkg;

    typedef enum logic [2:0] {
        ST_SEND     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_ABORT    = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    localparam int c_DEF_WIDTH = 17;
    localparam int c_EOP_BIT   = c_DEF_WIDTH - 1;

    function automatic int eop_bit(input int w);
        return w - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_pkt_replay.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkt_replay
// Description : Read-side replay controller for sd_fifo_b; forwards a packet,
//               then commits on ack or rewinds the FIFO on nack.
// Revision    : 1.0
// ============================================================================
module sd_pkt_replay
    import sd_pkt_replay_pkg::*;
#(
    parameter int WIDTH     = 17,
    parameter int MAX_RETRY = 3,
    parameter int RSZ       = $clog2(MAX_RETRY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [WIDTH-1:0] c_data,
    output logic             c_commit,
    output logic             c_abort,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [WIDTH-1:0] p_data,
    input  logic             ack_srdy,
    output logic             ack_drdy,
    input  logic             ack_ok,
    output logic [RSZ-1:0]   retry_cnt,
    output logic             pkt_done,
    output logic             pkt_drop
);

    localparam int c_EOP = eop_bit(WIDTH);

    state_t         r_state;
    logic [RSZ-1:0] r_retry_cnt;
    logic           w_send;
    logic           w_xfer_eop;

    // Handshakes are gated by reset so they are quiet while it is held.
    assign w_send     = reset && (r_state == ST_SEND);
    assign w_xfer_eop = w_send && c_srdy && p_drdy && c_data[c_EOP];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_SEND;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                ST_SEND: begin
                    if (w_xfer_eop)
                        r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_srdy) begin
                        if (ack_ok) begin
                            r_state <= ST_COMMIT;
                        end else if (r_retry_cnt < RSZ'(MAX_RETRY)) begin
                            r_state     <= ST_ABORT;
                            r_retry_cnt <= r_retry_cnt + RSZ'(1);
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_COMMIT, ST_DROP: begin
                    r_state     <= ST_SEND;
                    r_retry_cnt <= '0;
                end
                ST_ABORT: begin
                    r_state <= ST_SEND;
                end
                default: begin
                    r_state     <= ST_SEND;
                    r_retry_cnt <= '0;
                end
            endcase
        end
    end

    assign p_srdy    = w_send && c_srdy;
    assign c_drdy    = w_send && p_drdy;
    assign p_data    = c_data;
    assign ack_drdy  = reset && (r_state == ST_WAIT_ACK);
    assign c_commit  = (r_state == ST_COMMIT) || (r_state == ST_DROP);
    assign c_abort   = (r_state == ST_ABORT);
    assign pkt_done  = (r_state == ST_COMMIT);
    assign pkt_drop  = (r_state == ST_DROP);
    assign retry_cnt = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sd_pkt_replay.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_pkt_replay
// Description : Directed self-checking bench for sd_pkt_replay with a small
//               commit/abort FIFO read-side model.
// Revision    : 1.0
// ============================================================================
module tb_sd_pkt_replay;

    localparam int c_W  = 17;
    localparam int c_MR = 2;
    localparam int c_RS = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            c_srdy;
    logic            c_drdy;
    logic [c_W-1:0]  c_data;
    logic            c_commit, c_abort;
    logic            p_srdy;
    logic            p_drdy = 1'b0;
    logic [c_W-1:0]  p_data;
    logic            ack_srdy = 1'b0;
    logic            ack_drdy;
    logic            ack_ok = 1'b0;
    logic [c_RS-1:0] retry_cnt;
    logic            pkt_done, pkt_drop;

    int total = 0;
    int bad   = 0;

    // FIFO read-side model: rd rewinds to base on abort, base advances on commit.
    logic [c_W-1:0] mem [0:127];
    logic [6:0]     rd, base;
    logic [6:0]     wr = '0;

    assign c_srdy = (rd != wr);
    assign c_data = mem[rd];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd   <= '0;
            base <= '0;
        end else begin
            if (c_srdy && c_drdy) rd <= rd + 7'd1;
            if (c_commit) base <= rd;
            if (c_abort)  rd   <= base;
        end
    end

    logic [c_W-1:0] seen [0:255];
    int seen_n = 0, abort_n = 0;

    always @(posedge clk) begin
        if (reset && p_srdy && p_drdy) begin
            seen[seen_n[7:0]] <= p_data;
            seen_n <= seen_n + 1;
        end
        if (reset && c_abort) abort_n <= abort_n + 1;
    end

    sd_pkt_replay #(.WIDTH(c_W), .MAX_RETRY(c_MR)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .c_commit(c_commit), .c_abort(c_abort),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
        .ack_srdy(ack_srdy), .ack_drdy(ack_drdy), .ack_ok(ack_ok),
        .retry_cnt(retry_cnt), .pkt_done(pkt_done), .pkt_drop(pkt_drop)
    );

    always #5 clk = ~clk;

    task automatic load_pkt(input int first);
        for (int i = 0; i < 4; i++) begin
            mem[wr] = {(i == 3), 16'(first + i)};
            wr = wr + 7'd1;
        end
    endtask

    // Drives p_drdy until the EOP beat is accepted; counts c_drdy/p_drdy disagreements.
    task automatic deliver(input logic [7:0] pat, input bit use_pat, output bit ok, output int mism);
        int  cyc;
        bit  eop;
        cyc = 0; eop = 0; ok = 1; mism = 0;
        while (!eop) begin
            @(negedge clk);
            p_drdy = use_pat ? pat[cyc[2:0]] : 1'b1;
            #1;
            if (c_drdy !== p_drdy) mism++;
            if (p_srdy && p_drdy && p_data[c_W-1]) eop = 1;
            cyc++;
            if (cyc > 200) begin ok = 0; break; end
        end
        @(posedge clk);
    endtask

    // Returns sampled in the cycle after the ack handshake.
    task automatic send_ack(input bit okb, output bit tmo);
        int n;
        @(negedge clk);
        p_drdy = 1'b0; ack_srdy = 1'b1; ack_ok = okb;
        #1;
        n = 0;
        while (ack_drdy !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        tmo = (n >= 50);
        @(negedge clk);
        ack_srdy = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({p_srdy, c_drdy, ack_drdy, c_commit, c_abort, pkt_done, pkt_drop, retry_cnt} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outs: got %b want 0", {p_srdy, c_drdy, ack_drdy, c_commit, c_abort, pkt_done, pkt_drop, retry_cnt});
        end
        @(negedge clk); reset = 1'b1; p_drdy = 1'b1;
        #1;
        total++;
        if (c_drdy !== 1'b1 || ack_drdy !== 1'b0 || p_srdy !== 1'b0) begin
            bad++;
            $display("FAIL reset_send: c_drdy=%b ack_drdy=%b p_srdy=%b want 1 0 0", c_drdy, ack_drdy, p_srdy);
        end
        p_drdy = 1'b0;
    endtask

    task automatic test_ack;
        bit ok, tmo; int mism, b0, errs;
        b0 = seen_n;
        load_pkt(0);
        deliver(8'h00, 0, ok, mism);
        send_ack(1, tmo);
        total++;
        if (!ok || tmo || c_commit !== 1'b1 || pkt_done !== 1'b1 || pkt_drop !== 1'b0 || c_abort !== 1'b0) begin
            bad++;
            $display("FAIL ack_commit: ok=%b tmo=%b commit=%b done=%b drop=%b abort=%b want 1 0 1 1 0 0", ok, tmo, c_commit, pkt_done, pkt_drop, c_abort);
        end
        @(negedge clk); #1;
        total++;
        if (c_commit !== 1'b0 || pkt_done !== 1'b0 || (wr - base) !== 7'd0) begin
            bad++;
            $display("FAIL ack_pulse_end: commit=%b done=%b usage=%0d want 0 0 0", c_commit, pkt_done, wr - base);
        end
        errs = 0;
        for (int i = 0; i < 4; i++)
            if (seen[b0 + i] !== {(i == 3), 16'(i)}) errs++;
        total++;
        if (seen_n - b0 != 4 || errs != 0) begin
            bad++;
            $display("FAIL ack_words: count=%0d errs=%0d want 4 0", seen_n - b0, errs);
        end
    endtask

    task automatic test_nack_ack;
        bit ok1, ok2, tmo1, tmo2; int mism, b0, a0, errs;
        b0 = seen_n; a0 = abort_n;
        load_pkt(0);
        deliver(8'h00, 0, ok1, mism);
        send_ack(0, tmo1);
        total++;
        if (c_abort !== 1'b1 || c_commit !== 1'b0 || retry_cnt !== 2'd1) begin
            bad++;
            $display("FAIL nack_abort: abort=%b commit=%b retry=%0d want 1 0 1", c_abort, c_commit, retry_cnt);
        end
        deliver(8'h00, 0, ok2, mism);
        #1;
        total++;
        if (retry_cnt !== 2'd1) begin
            bad++;
            $display("FAIL nack_replay_retry: got %0d want 1", retry_cnt);
        end
        send_ack(1, tmo2);
        @(negedge clk); #1;
        total++;
        if (!ok1 || !ok2 || tmo1 || tmo2 || retry_cnt !== 2'd0 || abort_n - a0 != 1) begin
            bad++;
            $display("FAIL nack_final: retry=%0d aborts=%0d ok=%b%b tmo=%b%b want 0 1 11 00", retry_cnt, abort_n - a0, ok1, ok2, tmo1, tmo2);
        end
        errs = 0;
        for (int i = 0; i < 8; i++)
            if (seen[b0 + i] !== {(i % 4 == 3), 16'(i % 4)}) errs++;
        total++;
        if (seen_n - b0 != 8 || errs != 0) begin
            bad++;
            $display("FAIL nack_words: count=%0d errs=%0d want 8 0", seen_n - b0, errs);
        end
    endtask

    task automatic test_retry_exhaust;
        bit ok, tmo; int mism, b0, a0, errs, fails;
        b0 = seen_n; a0 = abort_n; fails = 0;
        load_pkt(0);
        load_pkt(4);
        for (int k = 0; k < 3; k++) begin
            deliver(8'h00, 0, ok, mism);
            send_ack(0, tmo);
            if (!ok || tmo) fails++;
        end
        total++;
        if (fails != 0 || pkt_drop !== 1'b1 || c_commit !== 1'b1 || c_abort !== 1'b0 || pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL drop_pulse: drop=%b commit=%b abort=%b done=%b fails=%0d want 1 1 0 0 0", pkt_drop, c_commit, c_abort, pkt_done, fails);
        end
        total++;
        if (abort_n - a0 != 2 || seen_n - b0 != 12) begin
            bad++;
            $display("FAIL drop_counts: aborts=%0d words=%0d want 2 12", abort_n - a0, seen_n - b0);
        end
        deliver(8'h00, 0, ok, mism);
        send_ack(1, tmo);
        errs = 0;
        for (int i = 0; i < 4; i++)
            if (seen[b0 + 12 + i] !== {(i == 3), 16'(4 + i)}) errs++;
        total++;
        if (!ok || tmo || errs != 0 || pkt_done !== 1'b1 || retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL drop_next_pkt: errs=%0d done=%b retry=%0d want 0 1 0", errs, pkt_done, retry_cnt);
        end
    endtask

    task automatic test_backpressure;
        bit ok, tmo; int mism, b0, errs, fails, mtot;
        b0 = seen_n; fails = 0; mtot = 0;
        load_pkt(8); load_pkt(12); load_pkt(16);
        for (int k = 0; k < 3; k++) begin
            deliver(8'h5A, 1, ok, mism);
            mtot += mism;
            send_ack(1, tmo);
            if (!ok || tmo) fails++;
        end
        total++;
        if (mtot != 0 || fails != 0) begin
            bad++;
            $display("FAIL bp_cdrdy: mismatches=%0d fails=%0d want 0 0", mtot, fails);
        end
        errs = 0;
        for (int i = 0; i < 12; i++)
            if (seen[b0 + i] !== {(i % 4 == 3), 16'(8 + i)}) errs++;
        total++;
        if (seen_n - b0 != 12 || errs != 0) begin
            bad++;
            $display("FAIL bp_words: count=%0d errs=%0d want 12 0", seen_n - b0, errs);
        end
    endtask

    task automatic test_early_ack;
        int errs;
        errs = 0;
        mem[wr] = 17'h10014; wr = wr + 7'd1;
        @(negedge clk);
        ack_srdy = 1'b1; ack_ok = 1'b1; p_drdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ack_drdy !== 1'b0 || c_commit !== 1'b0) errs++;
            @(negedge clk);
        end
        p_drdy = 1'b1;
        #1;
        total++;
        if (errs != 0 || ack_drdy !== 1'b0 || p_srdy !== 1'b1 || p_data !== 17'h10014) begin
            bad++;
            $display("FAIL early_hold: errs=%0d ack_drdy=%b p_srdy=%b data=%h want 0 0 1 10014", errs, ack_drdy, p_srdy, p_data);
        end
        @(negedge clk); p_drdy = 1'b0; #1;
        total++;
        if (ack_drdy !== 1'b1 || c_commit !== 1'b0) begin
            bad++;
            $display("FAIL early_wait: ack_drdy=%b commit=%b want 1 0", ack_drdy, c_commit);
        end
        @(negedge clk); ack_srdy = 1'b0; #1;
        total++;
        if (c_commit !== 1'b1 || pkt_done !== 1'b1 || ack_drdy !== 1'b0) begin
            bad++;
            $display("FAIL early_commit: commit=%b done=%b ack_drdy=%b want 1 1 0", c_commit, pkt_done, ack_drdy);
        end
    endtask

    task automatic test_reset_midpkt;
        bit ok, tmo; int mism, b0, errs;
        load_pkt(20);
        deliver(8'h00, 0, ok, mism);
        send_ack(0, tmo);
        deliver(8'h00, 0, ok, mism);
        @(negedge clk); p_drdy = 1'b0; #1;
        total++;
        if (ack_drdy !== 1'b1 || retry_cnt !== 2'd1) begin
            bad++;
            $display("FAIL rst_pre: ack_drdy=%b retry=%0d want 1 1", ack_drdy, retry_cnt);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (p_srdy !== 1'b0 || c_commit !== 1'b0 || retry_cnt !== 2'd0 || ack_drdy !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: p_srdy=%b commit=%b retry=%0d ack_drdy=%b want 0 0 0 0", p_srdy, c_commit, retry_cnt, ack_drdy);
        end
        wr = '0;
        load_pkt(24);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        b0 = seen_n;
        deliver(8'h00, 0, ok, mism);
        send_ack(1, tmo);
        errs = 0;
        for (int i = 0; i < 4; i++)
            if (seen[b0 + i] !== {(i == 3), 16'(24 + i)}) errs++;
        total++;
        if (!ok || tmo || errs != 0 || seen_n - b0 != 4 || pkt_done !== 1'b1) begin
            bad++;
            $display("FAIL rst_next_pkt: ok=%b tmo=%b errs=%0d words=%0d done=%b want 1 0 0 4 1", ok, tmo, errs, seen_n - b0, pkt_done);
        end
    endtask

    initial begin
        test_reset;
        test_ack;
        test_nack_ack;
        test_retry_exhaust;
        test_backpressure;
        test_early_ack;
        test_reset_midpkt;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_pkt_replay.md
Name: sd_pkt_replay

Overview:
- Read-side controller for sd_fifo_b; drives the FIFO's read-side p_commit/p_abort, which the FIFO owner otherwise ties to constants.
- Forwards one packet at a time from the FIFO read port to a downstream srdy/drdy consumer, then waits for an ack/nack.
- Ack commits the packet, freeing FIFO space. Nack aborts, rewinding the FIFO read pointer, and the packet is replayed.
- Sits between sd_fifo_b and a lossy link/transmit stage that reports delivery status.

Parameters:
- width, 17, data word width; bit width-1 is the end-of-packet (EOP) flag, bits width-2:0 are payload.
- max_retry, 3, number of nacks tolerated per packet before it is dropped (committed without delivery).
- rsz, $clog2(max_retry+1), width of the retry counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- c_srdy  in  1  FIFO read port has a word (connects to sd_fifo_b p_srdy)
- c_drdy  out  1  word accepted from FIFO (to sd_fifo_b p_drdy)
- c_data  in  width  FIFO read data (from sd_fifo_b p_data)
- c_commit  out  1  read-side commit pulse (to sd_fifo_b p_commit)
- c_abort  out  1  read-side abort pulse (to sd_fifo_b p_abort)
- p_srdy  out  1  downstream word valid
- p_drdy  in  1  downstream ready
- p_data  out  width  downstream data, EOP bit included
- ack_srdy  in  1  delivery status valid
- ack_drdy  out  1  status accepted
- ack_ok  in  1  1 = ack, 0 = nack
- retry_cnt  out  rsz  nacks received for the current packet
- pkt_done  out  1  one-cycle pulse when a packet is committed after an ack
- pkt_drop  out  1  one-cycle pulse when a packet is committed after retries are exhausted

Behaviour:
- Reset (reset low, asynchronous): state=SEND, retry_cnt=0.
  - All pulses 0 (c_commit, c_abort, pkt_done, pkt_drop).
  - All handshake outputs 0 while reset is held.
- State SEND:
  - Pass-through, zero latency: p_srdy=c_srdy, c_drdy=p_drdy, p_data=c_data; ack_drdy=0.
  - A transfer occurs when c_srdy & p_drdy.
  - A transfer with c_data[width-1]=1 moves to WAIT_ACK on the next edge.
- State WAIT_ACK:
  - c_drdy=0, p_srdy=0, ack_drdy=1.
  - ack_srdy asserted during SEND is not consumed; it is held off until WAIT_ACK.
  - ack_srdy & ack_ok: go to COMMIT.
  - ack_srdy & !ack_ok & retry_cnt<max_retry: go to ABORT and increment retry_cnt.
  - ack_srdy & !ack_ok & retry_cnt==max_retry: go to DROP.
- State COMMIT (1 cycle):
  - c_commit=1, pkt_done=1, all handshakes 0.
  - retry_cnt cleared; next state SEND.
- State DROP (1 cycle):
  - c_commit=1, pkt_drop=1, all handshakes 0.
  - retry_cnt cleared; next state SEND.
- State ABORT (1 cycle):
  - c_abort=1, c_drdy=0, p_srdy=0.
  - Next state SEND; the FIFO replays from the first word of the packet.
  - retry_cnt holds its value.
- Pulse and handshake outputs are decoded from registered state only; they have no combinational path from ack_*.
- Ack-to-commit latency: c_commit is asserted in the cycle after the ack handshake.
- c_commit and c_abort are never asserted in the same cycle.
- Single-word packet (EOP on the first beat) is legal: SEND lasts 1 transfer, then WAIT_ACK.
- A packet must be ≤ FIFO depth-1 words. A longer packet deadlocks, because an uncommitted FIFO reports full; this is the system's responsibility and is not checked here.
- retry_cnt saturates at max_retry and never wraps.
- Reset mid-packet: the block returns to SEND immediately. The FIFO must be reset in the same event so that no partial packet remains.

Decomposition:
- Shared package holds the state encoding (SEND, WAIT_ACK, COMMIT, ABORT, DROP) and an EOP bit-index constant (width-1).
- No sub-module is needed: one state register, one counter, and combinational steering.

Test Plan:
- All tests use width=17, max_retry=2, sd_fifo_b depth 32, and 4-word packets with payload 0..3.
- Ack: p side sees words 0,1,2,3+EOP; ack on the next cycle gives c_commit=1 and pkt_done=1 for exactly 1 cycle, 1 cycle after the ack handshake; sd_fifo_b usage returns to 0.
- Nack then ack: p side sees 0,1,2,3 twice; c_abort is pulsed once; retry_cnt is 1 during the replay and 0 after the commit.
- Retries exhausted: nacks 3 times in a row; there are 2 aborts, then pkt_drop=1 and c_commit=1 for one cycle; 12 words are seen; the next packet (payload 4..7) is delivered normally.
- Backpressure: p_drdy pattern 8'h5A over 3 packets with acks; no loss or duplication; c_drdy matches p_drdy every cycle in SEND.
- Early ack: ack_srdy=1, ack_ok=1 held from the start of SEND; ack_drdy stays 0 until after the EOP beat; the commit happens only after the single-word packet completes.
- Reset: reset pulsed low while in WAIT_ACK; p_srdy, c_commit and retry_cnt are 0 immediately (asynchronously); after release the block is in SEND and the next packet is delivered.
